crib_entry_buffer: RTL

Upstream front end for `bombe`. Turns the raw push-button and switch character into debounced, validated letter entries and stores them in an ordered crib buffer. On `go`, streams the buffer to `bombe` over a valid/ready handshake. Replaces direct wiring of `SW[7:0]`, `~KEY[3]` and `~KEY[0]` into the bombe.

---
 rtl/enigma_pkg.sv | 18 +
 rtl/input_debouncer.sv | 61 ++++++
 rtl/crib_entry_buffer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma/bombe front end: alphabet limits, letter
// width and the crib entry FSM states.
package enigma_pkg;

    localparam int ALPHABET_SIZE = 26;
    localparam int CHAR_W        = 8;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } entry_state_t;

    function automatic logic is_letter(input logic [CHAR_W-1:0] c);
        return c < CHAR_W'(ALPHABET_SIZE);
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Synchronizes a raw button and only follows it once the synchronized value has
// disagreed with the debounced level for DEBOUNCE_CYCLES consecutive cycles.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every _d gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/crib_entry_buffer.sv
// Collects debounced letter presses into an ordered crib buffer and streams it
// to the bombe over valid/ready when go is pressed; go in DONE replays it.
module crib_entry_buffer
    import enigma_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CHAR_W-1:0]       char_in,
    input  logic                    key_press,
    input  logic                    go,
    output logic [CHAR_W-1:0]       out_char,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    bad_char,
    output logic                    overflow,
    output logic                    streaming
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic         press_p, go_p;
    logic         key_level, go_level;
    logic         unused_levels;

    entry_state_t state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;

    logic char_ok, is_full, is_last;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk   (clk),
        .reset (reset),
        .raw   (key_press),
        .level (key_level),
        .rise  (press_p)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_db (
        .clk   (clk),
        .reset (reset),
        .raw   (go),
        .level (go_level),
        .rise  (go_p)
    );

    // Debounced levels are only useful when probing the design.
    assign unused_levels = key_level ^ go_level;

    assign char_ok = is_letter(char_in);
    assign is_full = (count_q == CW'(DEPTH));
    assign is_last = ({1'b0, rd_ptr_q} == count_q - CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the entry array is deliberately not reset; count bounds every read
    // and out_char is forced to zero outside STREAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= char_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        unique case (state_q)
            LOAD: begin
                if (press_p && char_ok && !is_full) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + CW'(1);
                end
                if (go_p && count_q != '0) begin
                    rd_ptr_d = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (is_last) state_d = DONE;
                end
            end
            DONE: begin
                if (go_p) begin
                    rd_ptr_d = '0;
                    state_d  = STREAM;
                end else if (press_p) begin
                    // A press in DONE starts a fresh crib and is itself entry 0.
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    if (char_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                        wr_ptr_d  = AW'(1);
                        count_d   = CW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        streaming = (state_q == STREAM);
        out_valid = streaming;
        out_char  = streaming ? mem_q[rd_ptr_q] : '0;
        out_last  = streaming && is_last;
        bad_char  = press_p && !char_ok &&
                    ((state_q == LOAD) || (state_q == DONE && !go_p));
        overflow  = press_p && char_ok && is_full && (state_q == LOAD);
    end

    assign count = count_q;
    assign full  = is_full;
    assign empty = (count_q == '0);

endmodule
